// File: rtl/majority_vote_pkg.sv
// Shared types and helpers for the streaming majority/tie voter.
package majority_vote_pkg;

  typedef enum logic [1:0] {ACCUM, WAIT, HOLD} state_t;

  localparam int HIST_W = 16;

  // Width that holds every possible yes-count of one group (0 .. n*rounds).
  function automatic int count_width(input int n, input int rounds);
    return $clog2(n * rounds + 1);
  endfunction

endpackage

// File: rtl/majority_vote_acc_popcount.sv
// Combinational ones count of an N-bit vector.
module popcount #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N + 1)
) (
  input  logic [N-1:0]  bits,
  output logic [PW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) count = count + PW'(bits[i]);
  end

endmodule

// File: rtl/majority_vote_acc.sv
// Pipelined majority/tie voter: accumulates ROUNDS N-bit vote vectors per decision.
// Optional VOTE_HIST_EN adds saturating decision-history counters.
module majority_vote_acc
  import majority_vote_pkg::*;
#(
  parameter  int N      = 4,
  parameter  int ROUNDS = 1,
  localparam int CW     = count_width(N, ROUNDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_votes,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_result,
  output logic              out_tie,
  output logic [CW-1:0]     out_count
`ifdef VOTE_HIST_EN
  ,
  output logic [HIST_W-1:0] hist_major,
  output logic [HIST_W-1:0] hist_tie
`endif
);

  localparam int             PW       = $clog2(N + 1);
  localparam int             RW       = $clog2(ROUNDS + 1);
  localparam logic [RW-1:0]  LAST_RND = RW'(ROUNDS - 1);
  localparam logic [CW+1:0]  TOTAL    = (CW + 2)'(N * ROUNDS);

  state_t        state, state_nx;
  logic [RW-1:0] rnd;
  logic [PW-1:0] pop, s1_pop;
  logic          s1_vld, s1_last;
  logic [CW-1:0] acc;
  logic [CW:0]   sum;
  logic          accept, last, done, flush;

  assign flush  = rst | clr;
  assign last   = (rnd == LAST_RND);
  assign done   = out_valid & out_ready;
  assign accept = in_valid & in_ready;
  assign sum    = {1'b0, acc} + (CW + 1)'(s1_pop);

  popcount #(.N(N)) u_pop (.bits(in_votes), .count(pop));

  // HOLD lets a new group start in the same cycle the decision is taken.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last) state_nx = WAIT;
      end
      WAIT: if (s1_vld && s1_last) state_nx = HOLD;
      HOLD: begin
        in_ready = out_ready;
        if (done) state_nx = (in_valid && last) ? WAIT : ACCUM;
      end
      default: state_nx = ACCUM;
    endcase
    if (flush) begin
      in_ready = 1'b0;
      state_nx = ACCUM;
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state      <= ACCUM;
      rnd        <= '0;
      s1_vld     <= 1'b0;
      s1_pop     <= '0;
      s1_last    <= 1'b0;
      acc        <= '0;
      out_valid  <= 1'b0;
      out_result <= 1'b0;
      out_tie    <= 1'b0;
      out_count  <= '0;
    end else begin
      state  <= state_nx;
      s1_vld <= accept;
      if (accept) begin
        s1_pop  <= pop;
        s1_last <= last;
        rnd     <= last ? '0 : rnd + 1'b1;
      end
      if (done) out_valid <= 1'b0;
      if (s1_vld) begin
        if (s1_last) begin
          acc        <= '0;
          out_valid  <= 1'b1;
          out_count  <= sum[CW-1:0];
          out_result <= {sum, 1'b0} > TOTAL;
          out_tie    <= {sum, 1'b0} == TOTAL;
        end else begin
          acc <= sum[CW-1:0];
        end
      end
    end
  end

`ifdef VOTE_HIST_EN
  // History survives clr; only a delivered decision counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_major <= '0;
      hist_tie   <= '0;
    end else if (done && !clr) begin
      if (out_result && hist_major != '1) hist_major <= hist_major + 1'b1;
      if (out_tie && hist_tie != '1)      hist_tie   <= hist_tie + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_majority_vote_acc.sv
// Scoreboard bench: three voter instances (4x1, 4x3, 5x1) share one clock and reset.
module tb_majority_vote_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] iv, clr_v, ordy;
  logic [4:0] vot [3];

  logic       ir_a, ov_a, res_a, tie_a;
  logic [2:0] cnt_a;
  logic       ir_b, ov_b, res_b, tie_b;
  logic [3:0] cnt_b;
  logic       ir_c, ov_c, res_c, tie_c;
  logic [2:0] cnt_c;
  logic [2:0] irdy, ovv;
`ifdef VOTE_HIST_EN
  logic [15:0] hm_a, ht_a, hm_b, ht_b, hm_c, ht_c;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {bit r; bit t; int c;} exp_t;
  exp_t qa[$], qb[$], qc[$];

  assign irdy = {ir_c, ir_b, ir_a};
  assign ovv  = {ov_c, ov_b, ov_a};

  always #5 clk = ~clk;

  majority_vote_acc #(.N(4), .ROUNDS(1)) dut_a (
    .clk(clk), .rst(rst), .clr(clr_v[0]), .in_valid(iv[0]), .in_ready(ir_a),
    .in_votes(vot[0][3:0]), .out_valid(ov_a), .out_ready(ordy[0]),
    .out_result(res_a), .out_tie(tie_a), .out_count(cnt_a)
`ifdef VOTE_HIST_EN
    , .hist_major(hm_a), .hist_tie(ht_a)
`endif
  );

  majority_vote_acc #(.N(4), .ROUNDS(3)) dut_b (
    .clk(clk), .rst(rst), .clr(clr_v[1]), .in_valid(iv[1]), .in_ready(ir_b),
    .in_votes(vot[1][3:0]), .out_valid(ov_b), .out_ready(ordy[1]),
    .out_result(res_b), .out_tie(tie_b), .out_count(cnt_b)
`ifdef VOTE_HIST_EN
    , .hist_major(hm_b), .hist_tie(ht_b)
`endif
  );

  majority_vote_acc #(.N(5), .ROUNDS(1)) dut_c (
    .clk(clk), .rst(rst), .clr(clr_v[2]), .in_valid(iv[2]), .in_ready(ir_c),
    .in_votes(vot[2]), .out_valid(ov_c), .out_ready(ordy[2]),
    .out_result(res_c), .out_tie(tie_c), .out_count(cnt_c)
`ifdef VOTE_HIST_EN
    , .hist_major(hm_c), .hist_tie(ht_c)
`endif
  );

  function automatic exp_t model(input int n, input int rounds, input int c);
    exp_t e;
    e.r = (2 * c > n * rounds);
    e.t = (2 * c == n * rounds);
    e.c = c;
    return e;
  endfunction

  function automatic int qsize(input int d);
    case (d)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  // Monitors: a decision is delivered when out_valid & out_ready with no flush.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && !clr_v[0] && ov_a && ordy[0]) begin
      n_cmp++;
      if (qa.size() == 0) begin
        n_bad++;
        $display("FAIL dec_a: unexpected decision r=%0b t=%0b cnt=%0d", res_a, tie_a, cnt_a);
      end else begin
        e = qa.pop_front();
        if (res_a !== e.r || tie_a !== e.t || int'(cnt_a) !== e.c) begin
          n_bad++;
          $display("FAIL dec_a: got r=%0b t=%0b cnt=%0d, required r=%0b t=%0b cnt=%0d",
                   res_a, tie_a, cnt_a, e.r, e.t, e.c);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && !clr_v[1] && ov_b && ordy[1]) begin
      n_cmp++;
      if (qb.size() == 0) begin
        n_bad++;
        $display("FAIL dec_b: unexpected decision r=%0b t=%0b cnt=%0d", res_b, tie_b, cnt_b);
      end else begin
        e = qb.pop_front();
        if (res_b !== e.r || tie_b !== e.t || int'(cnt_b) !== e.c) begin
          n_bad++;
          $display("FAIL dec_b: got r=%0b t=%0b cnt=%0d, required r=%0b t=%0b cnt=%0d",
                   res_b, tie_b, cnt_b, e.r, e.t, e.c);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && !clr_v[2] && ov_c && ordy[2]) begin
      n_cmp++;
      if (qc.size() == 0) begin
        n_bad++;
        $display("FAIL dec_c: unexpected decision r=%0b t=%0b cnt=%0d", res_c, tie_c, cnt_c);
      end else begin
        e = qc.pop_front();
        if (res_c !== e.r || tie_c !== e.t || int'(cnt_c) !== e.c) begin
          n_bad++;
          $display("FAIL dec_c: got r=%0b t=%0b cnt=%0d, required r=%0b t=%0b cnt=%0d",
                   res_c, tie_c, cnt_c, e.r, e.t, e.c);
        end
      end
    end
  end

  // All driving tasks start and end 1 time unit after a rising edge.
  task automatic send(input int d, input logic [4:0] v);
    int t = 0;
    iv[d]  = 1'b1;
    vot[d] = v;
    @(negedge clk);
    while (!irdy[d] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!irdy[d]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_%0d: in_ready stayed %0b, required 1", d, irdy[d]);
    end
    @(posedge clk); #1;
    iv[d] = 1'b0;
  endtask

  task automatic wait_drain(input int d);
    int t = 0;
    while (qsize(d) != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (qsize(d) != 0) begin
      n_bad++;
      $display("FAIL drain_%0d: %0d decisions pending, required 0", d, qsize(d));
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input int d);
    int t = 0;
    @(negedge clk);
    while (!ovv[d] && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (!ovv[d]) begin
      n_bad++;
      $display("FAIL valid_%0d: out_valid=%0b, required 1", d, ovv[d]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; iv = '0; clr_v = '0; ordy = 3'b111;
    for (int i = 0; i < 3; i++) vot[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (ir_a !== 1'b0 || ir_b !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_ready: in_ready a=%0b b=%0b, required 0", ir_a, ir_b);
    end
    n_cmp++;
    if (ov_a !== 1'b0 || res_a !== 1'b0 || tie_a !== 1'b0 || cnt_a !== 3'd0 || ov_b !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_out: v=%0b r=%0b t=%0b cnt=%0d vb=%0b, required all 0",
               ov_a, res_a, tie_a, cnt_a, ov_b);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ir_a !== 1'b1 || ir_b !== 1'b1 || ir_c !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_release: in_ready=%b, required 111", irdy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    qa.push_back(model(4, 1, 3));
    iv[0] = 1'b1; vot[0] = 5'b01011;
    @(negedge clk);
    n_cmp++;
    if (ir_a !== 1'b1) begin
      n_bad++;
      $display("FAIL lat_ready: in_ready=%0b, required 1", ir_a);
    end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ov_a !== 1'b0 || ir_a !== 1'b0) begin
      n_bad++;
      $display("FAIL lat_k1: out_valid=%0b in_ready=%0b, required 0 0", ov_a, ir_a);
    end
    @(negedge clk);
    n_cmp++;
    if (ov_a !== 1'b1) begin
      n_bad++;
      $display("FAIL lat_k2: out_valid=%0b, required 1", ov_a);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_round1();
    qa.push_back(model(4, 1, 3));
    qa.push_back(model(4, 1, 2));
    qa.push_back(model(4, 1, 1));
    send(0, 5'b01011);
    send(0, 5'b00011);
    send(0, 5'b00001);
    wait_drain(0);
  endtask

  task automatic test_rounds3();
    qb.push_back(model(4, 3, 6));
    send(1, 5'b01111);
    send(1, 5'b00000);
    send(1, 5'b00011);
    @(negedge clk);
    n_cmp++;
    if (ir_b !== 1'b0 || ov_b !== 1'b0) begin
      n_bad++;
      $display("FAIL r3_wait: in_ready=%0b out_valid=%0b, required 0 0", ir_b, ov_b);
    end
    @(negedge clk);
    n_cmp++;
    if (ov_b !== 1'b1 || ir_b !== 1'b1) begin
      n_bad++;
      $display("FAIL r3_hold: out_valid=%0b in_ready=%0b, required 1 1", ov_b, ir_b);
    end
    wait_drain(1);
  endtask

  task automatic test_odd();
    qc.push_back(model(5, 1, 3));
    qc.push_back(model(5, 1, 2));
    send(2, 5'b11100);
    send(2, 5'b11000);
    wait_drain(2);
  endtask

  task automatic test_back_to_back();
    ordy[0] = 1'b0;
    qa.push_back(model(4, 1, 4));
    send(0, 5'b01111);
    wait_valid(0);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (ov_a !== 1'b1 || cnt_a !== 3'd4 || res_a !== 1'b1 || ir_a !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold%0d: v=%0b cnt=%0d r=%0b rdy=%0b, required 1 4 1 0",
                 i, ov_a, cnt_a, res_a, ir_a);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    qa.push_back(model(4, 1, 0));
    ordy[0] = 1'b1; iv[0] = 1'b1; vot[0] = 5'b00000;
    @(negedge clk);
    n_cmp++;
    if (ir_a !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_same_cycle: in_ready=%0b, required 1", ir_a);
    end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    wait_drain(0);
  endtask

  task automatic test_clr();
    send(1, 5'b01111);
    send(1, 5'b01111);
    clr_v[1] = 1'b1; iv[1] = 1'b1; vot[1] = 5'b01111;
    @(negedge clk);
    n_cmp++;
    if (ir_b !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_ready: in_ready=%0b, required 0", ir_b);
    end
    @(posedge clk); #1;
    clr_v[1] = 1'b0; iv[1] = 1'b0;
    qb.push_back(model(4, 3, 0));
    send(1, 5'b00000);
    send(1, 5'b00000);
    send(1, 5'b00000);
    wait_drain(1);
    // abort a decision held in HOLD, racing a handshake
    ordy[1] = 1'b0;
    send(1, 5'b01111);
    send(1, 5'b01111);
    send(1, 5'b01111);
    wait_valid(1);
    @(posedge clk); #1;
    clr_v[1] = 1'b1; ordy[1] = 1'b1;
    @(posedge clk); #1;
    clr_v[1] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ov_b !== 1'b0 || ir_b !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_hold: out_valid=%0b in_ready=%0b, required 0 1", ov_b, ir_b);
    end
    @(posedge clk); #1;
  endtask

`ifdef VOTE_HIST_EN
  task automatic test_hist();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      qa.push_back(model(4, 1, 4));
      send(0, 5'b01111);
    end
    for (int i = 0; i < 2; i++) begin
      qa.push_back(model(4, 1, 2));
      send(0, 5'b00011);
    end
    wait_drain(0);
    clr_v[0] = 1'b1;
    @(posedge clk); #1;
    clr_v[0] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (hm_a !== 16'd3 || ht_a !== 16'd2) begin
      n_bad++;
      $display("FAIL hist_count: major=%0d tie=%0d, required 3 2", hm_a, ht_a);
    end
    @(posedge clk); #1;
    force dut_a.hist_major = 16'hFFFE;
    @(posedge clk); #1;
    release dut_a.hist_major;
    for (int i = 0; i < 2; i++) begin
      qa.push_back(model(4, 1, 4));
      send(0, 5'b01111);
    end
    wait_drain(0);
    n_cmp++;
    if (hm_a !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL hist_sat: major=%h, required ffff", hm_a);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_round1();
    test_rounds3();
    test_odd();
    test_back_to_back();
    test_clr();
`ifdef VOTE_HIST_EN
    test_hist();
`endif
    repeat (4) @(posedge clk);
    n_cmp++;
    if (qa.size() + qb.size() + qc.size() != 0) begin
      n_bad++;
      $display("FAIL final_queues: %0d pending, required 0", qa.size() + qb.size() + qc.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
